// File: rtl/vga_text_render_if.sv
// Memory-side bus of the text renderer: text VRAM cell fetch and font ROM
// glyph-row fetch, both synchronous reads with one cycle of latency.
interface vga_text_render_if;
    logic [10:0] vram_addr;
    logic [15:0] vram_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;

    modport master (
        output vram_addr,
        output font_addr,
        input  vram_data,
        input  font_data
    );

    modport slave (
        input  vram_addr,
        input  font_addr,
        output vram_data,
        output font_data
    );
endinterface

// File: rtl/vga_text_render.sv
// 80x25 text-mode pixel stage: 8x16 glyphs, CGA palette, hardware cursor
// and blink, with syncs delayed to stay aligned with the pixel pipeline.
module vga_text_render #(
    parameter int COLS     = 80,
    parameter int ROWS     = 25,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 400,
    parameter int PIPE_LAT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [9:0]        counter_x,
    input  logic [9:0]        counter_y,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    vga_text_render_if.master mem,
    input  logic              cursor_en,
    input  logic [10:0]       cursor_pos,
    input  logic              blink_en,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_h_sync,
    output logic              vga_v_sync
);
    localparam logic [9:0]  HA    = 10'(H_ACTIVE);
    localparam logic [9:0]  VA    = 10'(V_ACTIVE);
    localparam logic [10:0] NC    = 11'(COLS);
    localparam logic [10:0] CELLS = 11'(COLS * ROWS);
    localparam int          SD    = PIPE_LAT - 1;

    function automatic logic [3:0] lvl(input logic b, input logic i);
        if (b) return i ? 4'hF : 4'hA;
        return i ? 4'h5 : 4'h0;
    endfunction

    function automatic logic [11:0] pal(input logic [3:0] c);
        logic [3:0] g;
        g = (c == 4'd6) ? 4'h5 : lvl(c[1], c[3]);
        return {lvl(c[2], c[3]), g, lvl(c[0], c[3])};
    endfunction

    logic        de_d;
    logic [10:0] cell_d;
    logic [10:0] addr_d;
    logic        hit_d;

    logic [10:0] addr_q;
    logic [2:0]  col1_q, col2_q, col3_q;
    logic [3:0]  grow1_q, grow2_q;
    logic        de1_q, de2_q, de3_q;
    logic        hit1_q, hit2_q, hit3_q;
    logic [7:0]  attr3_q;
    logic [11:0] rgb_d, rgb_q;
    logic [SD-1:0] hs_q, vs_q;
    logic        vsp_q;
    logic [5:0]  frame_q;

    logic        pix;
    logic        blank_ph;
    logic        on;
    logic [3:0]  idx;

    always_comb begin
        de_d   = (counter_x < HA) && (counter_y < VA);
        cell_d = {5'd0, counter_y[9:4]} * NC + {4'd0, counter_x[9:3]};
        addr_d = (de_d && (cell_d < CELLS)) ? cell_d : 11'd0;
        hit_d  = cursor_en && (addr_d == cursor_pos)
                 && (counter_y[3:0] >= 4'd14);
    end

    // Glyph fetch is issued straight off the VRAM read data.
    assign mem.vram_addr = addr_q;
    assign mem.font_addr = de2_q ? {mem.vram_data[7:0], grow2_q} : 12'd0;

    always_comb begin
        pix      = mem.font_data[~col3_q];
        blank_ph = blink_en && attr3_q[7] && frame_q[5];
        on       = (pix && !blank_ph) || (hit3_q && frame_q[4]);
        idx      = on ? attr3_q[3:0]
                      : {blink_en ? 1'b0 : attr3_q[7], attr3_q[6:4]};
        rgb_d    = de3_q ? pal(idx) : 12'd0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            col1_q  <= '0;
            col2_q  <= '0;
            col3_q  <= '0;
            grow1_q <= '0;
            grow2_q <= '0;
            de1_q   <= 1'b0;
            de2_q   <= 1'b0;
            de3_q   <= 1'b0;
            hit1_q  <= 1'b0;
            hit2_q  <= 1'b0;
            hit3_q  <= 1'b0;
            attr3_q <= '0;
            rgb_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            col1_q  <= counter_x[2:0];
            grow1_q <= counter_y[3:0];
            de1_q   <= de_d;
            hit1_q  <= hit_d;
            col2_q  <= col1_q;
            grow2_q <= grow1_q;
            de2_q   <= de1_q;
            hit2_q  <= hit1_q;
            col3_q  <= col2_q;
            de3_q   <= de2_q;
            hit3_q  <= hit2_q;
            attr3_q <= mem.vram_data[15:8];
            rgb_q   <= rgb_d;
        end
    end

    // Incoming syncs already trail the counters by one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hs_q    <= '1;
            vs_q    <= '1;
            vsp_q   <= 1'b1;
            frame_q <= '0;
        end else begin
            hs_q  <= {hs_q[SD-2:0], h_sync_in};
            vs_q  <= {vs_q[SD-2:0], v_sync_in};
            vsp_q <= v_sync_in;
            if (vsp_q && !v_sync_in) frame_q <= frame_q + 6'd1;
        end
    end

    assign vga_r      = rgb_q[11:8];
    assign vga_g      = rgb_q[7:4];
    assign vga_b      = rgb_q[3:0];
    assign vga_h_sync = hs_q[SD-1];
    assign vga_v_sync = vs_q[SD-1];
endmodule

// File: tb/tb_vga_text_render.sv
// Scoreboard bench for vga_text_render: directed raster vectors, expected
// pixels/addresses/syncs queued with their due cycle and checked by a monitor.
module tb_vga_text_render;
  typedef struct {
    int          due;
    int          kind;
    logic [11:0] val;
    string       nm;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic [9:0]  cx, cy;
  logic        hs_in, vs_in;
  logic        cursor_en;
  logic [10:0] cursor_pos;
  logic        blink_en;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_h_sync, vga_v_sync;

  logic [15:0] vram [0:2047];
  logic [7:0]  font [0:4095];

  exp_t q[$];
  int   cyc;
  int   n_vec;
  int   n_fail;

  vga_text_render_if mif();

  vga_text_render dut (
    .clk        (clk),
    .resetn     (resetn),
    .counter_x  (cx),
    .counter_y  (cy),
    .h_sync_in  (hs_in),
    .v_sync_in  (vs_in),
    .mem        (mif),
    .cursor_en  (cursor_en),
    .cursor_pos (cursor_pos),
    .blink_en   (blink_en),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_h_sync (vga_h_sync),
    .vga_v_sync (vga_v_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    mif.vram_data <= vram[mif.vram_addr];
    mif.font_data <= font[mif.font_addr];
  end

  always @(negedge clk) begin
    logic [11:0] act;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due == cyc) begin
        case (q[i].kind)
          0:       act = {vga_r, vga_g, vga_b};
          1:       act = {1'b0, mif.vram_addr};
          2:       act = {11'd0, vga_h_sync};
          3:       act = {11'd0, vga_v_sync};
          default: act = mif.font_addr;
        endcase
        n_vec = n_vec + 1;
        if (act !== q[i].val) begin
          n_fail = n_fail + 1;
          $display("FAIL %s @cyc %0d: got %h, want %h",
                   q[i].nm, cyc, act, q[i].val);
        end
        q.delete(i);
      end
    end
  end

  function automatic void expect_at(input int due, input int kind,
                                    input logic [11:0] v, input string nm);
    exp_t e;
    e.due  = due;
    e.kind = kind;
    e.val  = v;
    e.nm   = nm;
    q.push_back(e);
  endfunction

  task automatic chk_rst(input string nm);
    n_vec = n_vec + 1;
    if ({vga_r, vga_g, vga_b} !== 12'h000 || vga_h_sync !== 1'b1 ||
        vga_v_sync !== 1'b1 || mif.vram_addr !== 11'd0 ||
        mif.font_addr !== 12'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: rgb %h hs %b vs %b va %h fa %h", nm,
               {vga_r, vga_g, vga_b}, vga_h_sync, vga_v_sync,
               mif.vram_addr, mif.font_addr);
    end
  endtask

  task automatic step(input int x, input int y, input logic hs,
                      input logic vs, input logic [11:0] rgb,
                      input int addr, input bit push);
    cx    = 10'(x);
    cy    = 10'(y);
    hs_in = hs;
    vs_in = vs;
    if (push) begin
      expect_at(cyc + 4, 0, rgb, $sformatf("rgb(%0d,%0d)", x, y));
      expect_at(cyc + 1, 1, 12'(addr),
                $sformatf("vram_addr(%0d,%0d)", x, y));
      expect_at(cyc + 3, 2, {11'd0, hs}, "h_sync");
      expect_at(cyc + 3, 3, {11'd0, vs}, "v_sync");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(700, 420, 1'b1, 1'b1, 12'h000, 0, 1'b1);
  endtask

  task automatic vpulses(input int n);
    for (int i = 0; i < n; i++) begin
      step(700, 420, 1'b1, 1'b0, 12'h000, 0, 1'b1);
      step(700, 420, 1'b1, 1'b1, 12'h000, 0, 1'b1);
    end
  endtask

  initial begin
    logic [11:0] t1 [0:7];
    t1 = '{12'h000, 12'h000, 12'h000, 12'hAAA,
           12'hAAA, 12'h000, 12'h000, 12'h000};
    n_vec  = 0;
    n_fail = 0;
    for (int i = 0; i < 2048; i++) vram[i] = 16'h0000;
    for (int i = 0; i < 4096; i++) font[i] = 8'h00;
    vram[0]    = 16'h0741;
    vram[5]    = 16'h8E02;
    vram[81]   = 16'h1F00;
    vram[1999] = 16'h1041;
    font[12'h410] = 8'h18;
    font[12'h020] = 8'hFF;

    resetn     = 1'b0;
    cx         = 10'd700;
    cy         = 10'd420;
    hs_in      = 1'b1;
    vs_in      = 1'b1;
    cursor_en  = 1'b0;
    cursor_pos = 11'd81;
    blink_en   = 1'b0;

    @(posedge clk);
    #1;
    chk_rst("reset state");
    expect_at(cyc, 0, 12'h000, "reset rgb");
    expect_at(cyc, 1, 12'h000, "reset vram_addr");
    expect_at(cyc, 2, 12'h001, "reset h_sync");
    expect_at(cyc, 3, 12'h001, "reset v_sync");
    expect_at(cyc, 4, 12'h000, "reset font_addr");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(2);

    for (int x = 0; x < 8; x++) step(x, 0, 1'b1, 1'b1, t1[x], 0, 1'b1);

    step(639, 399, 1'b1, 1'b1, 12'h00A, 1999, 1'b1);
    step(640, 399, 1'b1, 1'b1, 12'h000, 0, 1'b1);
    step(800, 0, 1'b1, 1'b1, 12'h000, 0, 1'b1);
    step(0, 400, 1'b1, 1'b1, 12'h000, 0, 1'b1);
    step(100, 50, 1'b1, 1'b1, 12'h000, 252, 1'b1);
    step(639, 0, 1'b1, 1'b1, 12'h000, 79, 1'b1);
    for (int i = 0; i < 3; i++) step(700, 420, 1'b0, 1'b1, 12'h000, 0, 1'b1);
    idle(4);

    cursor_en = 1'b1;
    for (int x = 8; x < 16; x++) step(x, 30, 1'b1, 1'b1, 12'h00A, 81, 1'b1);
    step(8, 29, 1'b1, 1'b1, 12'h00A, 81, 1'b1);
    idle(4);
    vpulses(16);
    for (int x = 8; x < 16; x++) step(x, 30, 1'b1, 1'b1, 12'hFFF, 81, 1'b1);
    step(12, 31, 1'b1, 1'b1, 12'hFFF, 81, 1'b1);
    step(8, 29, 1'b1, 1'b1, 12'h00A, 81, 1'b1);
    step(16, 30, 1'b1, 1'b1, 12'h000, 82, 1'b1);
    idle(1);
    cursor_pos = 11'd2000;
    step(8, 30, 1'b1, 1'b1, 12'h00A, 81, 1'b1);
    cursor_pos = 11'd1999;
    step(639, 399, 1'b1, 1'b1, 12'h000, 1999, 1'b1);
    idle(1);
    cursor_en  = 1'b0;
    cursor_pos = 11'd81;
    idle(4);

    blink_en = 1'b1;
    step(40, 0, 1'b1, 1'b1, 12'hFF5, 5, 1'b1);
    step(47, 0, 1'b1, 1'b1, 12'hFF5, 5, 1'b1);
    step(40, 1, 1'b1, 1'b1, 12'h000, 5, 1'b1);
    idle(4);
    vpulses(16);
    step(40, 0, 1'b1, 1'b1, 12'h000, 5, 1'b1);
    idle(4);
    blink_en = 1'b0;
    step(40, 0, 1'b1, 1'b1, 12'hFF5, 5, 1'b1);
    step(40, 1, 1'b1, 1'b1, 12'h555, 5, 1'b1);
    idle(4);

    vpulses(32);
    blink_en = 1'b1;
    step(40, 0, 1'b1, 1'b1, 12'hFF5, 5, 1'b1);
    idle(1);
    cursor_en = 1'b1;
    step(8, 30, 1'b1, 1'b1, 12'h00A, 81, 1'b1);
    idle(4);
    vpulses(16);
    step(8, 30, 1'b1, 1'b1, 12'hFFF, 81, 1'b1);
    idle(4);

    step(3, 0, 1'b0, 1'b1, 12'hAAA, 0, 1'b1);
    step(4, 0, 1'b0, 1'b1, 12'hAAA, 0, 1'b1);
    for (int i = 0; i < 4; i++) step(4, 0, 1'b0, 1'b1, 12'h000, 0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk_rst("async reset state");
    expect_at(cyc, 0, 12'h000, "async reset rgb");
    expect_at(cyc, 2, 12'h001, "async reset h_sync");
    expect_at(cyc, 4, 12'h000, "async reset font_addr");
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    resetn = 1'b1;
    for (int x = 0; x < 8; x++) step(x, 0, 1'b1, 1'b1, t1[x], 0, 1'b1);
    step(8, 30, 1'b1, 1'b1, 12'h00A, 81, 1'b1);
    for (int i = 0; i < 6; i++) step(700, 420, 1'b1, 1'b1, 12'h000, 0, 1'b0);

    n_vec = n_vec + 1;
    if (q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL expired wait: %0d expectations never checked",
               q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
